// File: rtl/msg_tx_pkg.sv
// Shared types and constants for the message transmit scheduler.
// Holds the FSM state enum, header field layout, output-buffer entry and header builder.
// Header word: {SYNC[15:12], SRC[11:9], PAR[8], LEN[7:0]}.
package msg_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SETTLE,
        S_HDR,
        S_DATA,
        S_DRAIN
    } state_t;

    localparam int          HDR_SYNC_LSB = 12;
    localparam int          HDR_SRC_LSB  = 9;
    localparam int          HDR_PAR_BIT  = 8;
    localparam int          HDR_LEN_LSB  = 0;
    localparam logic [3:0]  DEF_SYNC     = 4'hA;
    localparam logic [7:0]  MAX_LEN      = 8'd254;

    // One output-buffer entry.
    typedef struct packed {
        logic        eop;
        logic        sop;
        logic [15:0] dat;
    } obuf_t;

    function automatic logic [15:0] make_hdr(input logic [3:0] sync,
                                             input logic [2:0] src,
                                             input logic       par,
                                             input logic [7:0] len);
        logic [15:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 4] = sync;
        h[HDR_SRC_LSB  +: 3] = src;
        h[HDR_PAR_BIT]       = par;
        h[HDR_LEN_LSB  +: 8] = len;
        return h;
    endfunction

endpackage

// File: rtl/msg_tx_scheduler_if.sv
// Bundle of the scheduler's source-side handshake and downstream stream.
// master: scheduler side (drives MSG_START, RD_REQ, out_*); slave: sources + sink.
// Source i uses MSG_LEN[8i+7:8i] and FIFO_Q[16i+15:16i]; FIFO_Q is valid 1 cycle after RD_REQ.
interface msg_tx_scheduler_if #(parameter int N = 4);
    import msg_tx_pkg::*;

    logic [N-1:0]    GFM;
    logic [8*N-1:0]  MSG_LEN;
    logic [N-1:0]    PARITY;
    logic [16*N-1:0] FIFO_Q;
    logic [N-1:0]    MSG_START;
    logic [N-1:0]    RD_REQ;
    logic [15:0]     out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sop;
    logic            out_eop;

    modport master (
        input  GFM, MSG_LEN, PARITY, FIFO_Q, out_ready,
        output MSG_START, RD_REQ, out_data, out_valid, out_sop, out_eop
    );

    modport slave (
        output GFM, MSG_LEN, PARITY, FIFO_Q, out_ready,
        input  MSG_START, RD_REQ, out_data, out_valid, out_sop, out_eop
    );

endinterface

// File: rtl/msg_tx_scheduler_rr_arbiter.sv
// Round-robin pick of the first request at or after ptr, wrapping at N.
// Purely combinational; ports: req/ptr in, one-hot gnt, binary idx, any-request flag out.
// No backpressure: the caller decides when to take the grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [2:0]   idx,
    output logic         any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any                       = 1'b1;
                gnt[(int'(ptr) + i) % N]  = 1'b1;
                idx                       = 3'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/msg_tx_scheduler.sv
// Drains completed messages from N sources round-robin onto one 16-bit stream (header + payload).
// Latency: GFM -> MSG_START +1 cycle, header valid +3+SETTLE_CYC; RD_REQ -> word in buffer 2 cycles.
// Backpressure: 2-entry output buffer; reads are only issued while buffer + inflight stays <= 2.
module msg_tx_scheduler
    import msg_tx_pkg::*;
#(
    parameter int         N          = 4,
    parameter int         SETTLE_CYC = 4,
    parameter logic [3:0] SYNC       = DEF_SYNC
) (
    input  logic                  CLK,
    input  logic                  RST,
    msg_tx_scheduler_if.master    bus,
    output logic                  busy
);

    state_t        state, state_nxt;
    logic [2:0]    ptr;
    logic [2:0]    src;
    logic [N-1:0]  src_oh;
    logic [7:0]    len;
    logic          par;
    logic [7:0]    issued;
    logic [7:0]    settle_cnt;

    // Read pipeline: one stage between RD_REQ and the FIFO_Q word being pushed.
    logic          rd_v;
    logic          rd_eop;

    obuf_t         obuf_mem [2];
    logic          obuf_wp, obuf_rp;
    logic [1:0]    obuf_cnt;
    obuf_t         obuf_head;
    logic          obuf_vld;
    logic          pop;
    logic          push;
    obuf_t         push_ent;

    logic [N-1:0]  arb_gnt;
    logic [2:0]    arb_idx;
    logic          arb_any;

    logic          hdr_push;
    logic          rd_fire;
    logic [2:0]    credit_used;
    logic [2:0]    credit_lim;
    logic [7:0]    src_len;

    rr_arbiter #(.N(N)) u_arb (
        .req (bus.GFM),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign src_len = bus.MSG_LEN[int'(src)*8 +: 8];

    assign obuf_vld = (obuf_cnt != 2'd0);
    assign pop      = obuf_vld && bus.out_ready;

    // The word leaving this cycle frees a slot, so it is credited here; this keeps
    // 1 word/cycle with ready held high while buffer + inflight never exceeds 2.
    assign credit_used = {1'b0, obuf_cnt} + {2'b0, rd_v};
    assign credit_lim  = 3'd2 + {2'b0, pop};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        hdr_push      = 1'b0;
        rd_fire       = 1'b0;
        bus.MSG_START = '0;
        bus.RD_REQ    = '0;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE:   if (arb_any) state_nxt = S_START;
            S_START: begin
                bus.MSG_START = src_oh;
                state_nxt     = S_SETTLE;
            end
            S_SETTLE: if (settle_cnt == 8'(SETTLE_CYC - 1)) state_nxt = S_HDR;
            S_HDR: begin
                hdr_push  = 1'b1;
                state_nxt = (len == 8'd0) ? S_DRAIN : S_DATA;
            end
            S_DATA: begin
                rd_fire    = (issued < len) && (credit_used < credit_lim);
                bus.RD_REQ = rd_fire ? src_oh : '0;
                if (issued == len) state_nxt = S_DRAIN;
            end
            S_DRAIN:  if (!obuf_vld && !rd_v) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr        <= '0;
            src        <= '0;
            src_oh     <= '0;
            len        <= '0;
            par        <= 1'b0;
            issued     <= '0;
            settle_cnt <= '0;
            rd_v       <= 1'b0;
            rd_eop     <= 1'b0;
        end else begin
            rd_v   <= rd_fire;
            rd_eop <= rd_fire && (issued == len - 8'd1);
            if (rd_fire) issued <= issued + 8'd1;
            case (state)
                S_IDLE: if (arb_any) begin
                    src    <= arb_idx;
                    src_oh <= arb_gnt;
                end
                S_START: begin
                    issued     <= '0;
                    settle_cnt <= '0;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    // The source latched its length on the MSG_START edge.
                    if (settle_cnt == 8'd0) begin
                        len <= (src_len > MAX_LEN) ? MAX_LEN : src_len;
                        par <= bus.PARITY[src];
                    end
                end
                S_DRAIN: if (state_nxt == S_IDLE)
                    ptr <= (src == 3'(N - 1)) ? 3'd0 : src + 3'd1;
                default: ;
            endcase
        end
    end

    // Header and read returns never overlap: the pipe is empty while in HDR.
    assign push = hdr_push || rd_v;
    always_comb begin
        push_ent = '0;
        if (hdr_push) begin
            push_ent.dat = make_hdr(SYNC, src, par, len);
            push_ent.sop = 1'b1;
            push_ent.eop = (len == 8'd0);
        end else begin
            push_ent.dat = bus.FIFO_Q[int'(src)*16 +: 16];
            push_ent.eop = rd_eop;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            obuf_mem[0] <= '0;
            obuf_mem[1] <= '0;
            obuf_wp     <= 1'b0;
            obuf_rp     <= 1'b0;
            obuf_cnt    <= '0;
        end else begin
            if (push) begin
                obuf_mem[obuf_wp] <= push_ent;
                obuf_wp           <= ~obuf_wp;
            end
            if (pop) obuf_rp <= ~obuf_rp;
            obuf_cnt <= obuf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign obuf_head     = obuf_vld ? obuf_mem[obuf_rp] : '0;
    assign bus.out_valid = obuf_vld;
    assign bus.out_data  = obuf_head.dat;
    assign bus.out_sop   = obuf_head.sop;
    assign bus.out_eop   = obuf_head.eop;

endmodule
